// File: rtl/acq_pkg.sv
// Shared constants and types for the ping-pong ADC capture buffer:
// FSM states, bus register offsets, trigger source codes and CTRL bit positions.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SWAP    = 2'd3
    } acq_state_t;

    localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] REG_DEC     = 32'h0000_0004;
    localparam logic [31:0] REG_LEN     = 32'h0000_0008;
    localparam logic [31:0] REG_STATUS  = 32'h0000_000C;
    localparam logic [31:0] REG_RELEASE = 32'h0000_0010;
    localparam logic [31:0] RAM_BASE    = 32'h0001_0000;

    localparam logic [2:0] TRIG_NONE = 3'd0;
    localparam logic [2:0] TRIG_SW   = 3'd1;
    localparam logic [2:0] TRIG_EXT  = 3'd2;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_CONT    = 2;
    localparam int CTRL_SWTRIG  = 3;
    localparam int CTRL_SRC_LSB = 4;
    localparam int CTRL_SRC_MSB = 6;

endpackage

// File: rtl/red_pitaya_acq_double_buf_if.sv
// System-bus responder interface: one-cycle read/write strobes, acked data return.
interface red_pitaya_acq_double_buf_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    // Byte selects are not listed: the responder only supports full-word access.
    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/acq_bank_ram.sv
// Two capture banks in one simple dual-port RAM; the bank select is the address MSB.
module acq_bank_ram #(
    parameter int ADC_DW = 14,
    parameter int RSZ    = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [RSZ-1:0]    wr_addr,
    input  logic [ADC_DW-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [RSZ-1:0]    rd_addr,
    output logic [ADC_DW-1:0] rd_data
);
    logic [ADC_DW-1:0] mem [0:(2**(RSZ+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/red_pitaya_acq_double_buf.sv
// Ping-pong ADC capture: fills bank wb on a trigger, then hands it to the bus as bank rb
// and pulses irq_o. A bank stays readable until software releases it.
module red_pitaya_acq_double_buf
    import acq_pkg::*;
#(
    parameter int ADC_DW = 14,
    parameter int RSZ    = 14,
    parameter int DEC_W  = 17
) (
    input  logic                        adc_clk_i,
    input  logic                        adc_rst_i,
    input  logic [ADC_DW-1:0]           adc_dat_i,
    input  logic                        trig_i,
    output logic                        irq_o,
    red_pitaya_acq_double_buf_if.slave  sys
);
    localparam logic [RSZ:0]  LEN_MAX  = (RSZ+1)'(1) << RSZ;
    localparam logic [31:0]   RAM_SPAN = 32'(4) << RSZ;

    acq_state_t       state_reg;
    logic             wb_reg, rb_reg, ready_reg, overrun_reg;
    logic             cont_reg, trig_q_reg;
    logic [2:0]       trig_src_reg;
    logic [DEC_W-1:0] dec_reg, dec_cap_reg, deccnt_reg;
    logic [RSZ:0]     len_reg, len_cap_reg, count_reg;
    logic [RSZ-1:0]   wptr_reg;
    logic             ram_rd_pend_reg;
    logic [ADC_DW-1:0] ram_q;
    logic [31:0]      reg_rdata, status;

    logic ctrl_wr, dec_wr, len_wr, release_wr;
    logic arm_wr, abort_wr, sw_edge, ext_edge, trig_hit, ready_eff, ram_we, ram_hit;

    assign ctrl_wr    = sys.sys_wen && (sys.sys_addr == REG_CTRL);
    assign dec_wr     = sys.sys_wen && (sys.sys_addr == REG_DEC);
    assign len_wr     = sys.sys_wen && (sys.sys_addr == REG_LEN);
    assign release_wr = sys.sys_wen && (sys.sys_addr == REG_RELEASE) && sys.sys_wdata[0];
    assign arm_wr     = ctrl_wr && sys.sys_wdata[CTRL_ARM];
    assign abort_wr   = ctrl_wr && sys.sys_wdata[CTRL_ABORT];
    assign sw_edge    = ctrl_wr && sys.sys_wdata[CTRL_SWTRIG]
                        && (sys.sys_wdata[CTRL_SRC_MSB:CTRL_SRC_LSB] == TRIG_SW);
    assign ext_edge   = trig_i && !trig_q_reg;
    assign trig_hit   = ((trig_src_reg == TRIG_SW) && sw_edge)
                        || ((trig_src_reg == TRIG_EXT) && ext_edge);
    assign ram_hit    = (sys.sys_addr >= RAM_BASE) && (sys.sys_addr < (RAM_BASE + RAM_SPAN));

    // A release landing in the SWAP cycle counts as already applied.
    assign ready_eff  = ready_reg && !release_wr;
    assign irq_o      = (state_reg == ST_SWAP) && !ready_eff && !abort_wr;
    assign ram_we     = (state_reg == ST_CAPTURE) && (deccnt_reg == '0);

    acq_bank_ram #(
        .ADC_DW (ADC_DW),
        .RSZ    (RSZ)
    ) u_ram (
        .clk     (adc_clk_i),
        .we      (ram_we),
        .wr_bank (wb_reg),
        .wr_addr (wptr_reg),
        .wr_data (adc_dat_i),
        .rd_bank (rb_reg),
        .rd_addr (sys.sys_addr[RSZ+1:2]),
        .rd_data (ram_q)
    );

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_reg    <= ST_IDLE;
            wb_reg       <= 1'b0;
            rb_reg       <= 1'b1;
            ready_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
            cont_reg     <= 1'b0;
            trig_q_reg   <= 1'b0;
            trig_src_reg <= TRIG_NONE;
            dec_reg      <= DEC_W'(1);
            dec_cap_reg  <= DEC_W'(1);
            deccnt_reg   <= '0;
            len_reg      <= LEN_MAX;
            len_cap_reg  <= LEN_MAX;
            count_reg    <= '0;
            wptr_reg     <= '0;
        end else begin
            trig_q_reg <= trig_i;
            if (ctrl_wr) begin
                cont_reg     <= sys.sys_wdata[CTRL_CONT];
                trig_src_reg <= sys.sys_wdata[CTRL_SRC_MSB:CTRL_SRC_LSB];
            end
            if (dec_wr) begin
                dec_reg <= sys.sys_wdata[DEC_W-1:0];
            end
            if (len_wr) begin
                len_reg <= ((sys.sys_wdata == 32'd0) || (sys.sys_wdata > 32'(LEN_MAX)))
                           ? LEN_MAX : sys.sys_wdata[RSZ:0];
            end
            if (release_wr) begin
                ready_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (arm_wr) begin
                        state_reg <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Capture parameters are frozen here so mid-capture writes wait a round.
                    if (trig_hit) begin
                        state_reg   <= ST_CAPTURE;
                        wptr_reg    <= '0;
                        deccnt_reg  <= '0;
                        dec_cap_reg <= (dec_reg == '0) ? DEC_W'(1) : dec_reg;
                        len_cap_reg <= len_reg;
                    end
                end
                ST_CAPTURE: begin
                    deccnt_reg <= (deccnt_reg == dec_cap_reg - DEC_W'(1))
                                  ? '0 : deccnt_reg + DEC_W'(1);
                    if (deccnt_reg == '0) begin
                        wptr_reg <= wptr_reg + RSZ'(1);
                        if ({1'b0, wptr_reg} == len_cap_reg - (RSZ+1)'(1)) begin
                            state_reg <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    if (!ready_eff) begin
                        rb_reg    <= wb_reg;
                        wb_reg    <= ~wb_reg;
                        ready_reg <= 1'b1;
                        count_reg <= len_cap_reg;
                    end else begin
                        overrun_reg <= 1'b1;
                    end
                    state_reg <= cont_reg ? ST_ARMED : ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Abort also drops the completed-capture count: nothing is readable afterwards.
            if (abort_wr) begin
                state_reg   <= ST_IDLE;
                ready_reg   <= 1'b0;
                overrun_reg <= 1'b0;
                wb_reg      <= 1'b0;
                rb_reg      <= 1'b1;
                count_reg   <= '0;
            end
        end
    end

    always_comb begin
        status             = '0;
        status[0]          = (state_reg == ST_ARMED);
        status[1]          = (state_reg == ST_CAPTURE);
        status[2]          = ready_reg;
        status[3]          = overrun_reg;
        status[4]          = rb_reg;
        status[RSZ+16:16]  = count_reg;
    end

    always_comb begin
        reg_rdata = '0;
        case (sys.sys_addr)
            REG_CTRL:   reg_rdata = {25'd0, trig_src_reg, 1'b0, cont_reg, 2'b00};
            REG_DEC:    reg_rdata = 32'(dec_reg);
            REG_LEN:    reg_rdata = 32'(len_reg);
            REG_STATUS: reg_rdata = status;
            default:    reg_rdata = '0;
        endcase
    end

    assign sys.sys_err = 1'b0;

    // RAM reads take one extra cycle for the registered RAM output.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            sys.sys_ack     <= 1'b0;
            sys.sys_rdata   <= '0;
            ram_rd_pend_reg <= 1'b0;
        end else begin
            sys.sys_ack     <= sys.sys_wen;
            ram_rd_pend_reg <= 1'b0;
            if (sys.sys_ren) begin
                if (ram_hit) begin
                    ram_rd_pend_reg <= 1'b1;
                end else begin
                    sys.sys_ack   <= 1'b1;
                    sys.sys_rdata <= reg_rdata;
                end
            end
            if (ram_rd_pend_reg) begin
                sys.sys_ack   <= 1'b1;
                sys.sys_rdata <= {{(32-ADC_DW){ram_q[ADC_DW-1]}}, ram_q};
            end
        end
    end
endmodule

// File: tb/tb_red_pitaya_acq_double_buf.sv
// Directed bench: register table first, then hand-written capture sequences checked
// against hand-computed ramp values, bank/status bits and interrupt counts.
module tb_red_pitaya_acq_double_buf;
    import acq_pkg::*;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic [13:0] adc_dat = 14'd100;
    logic        trig = 1'b0;
    logic        irq;
    logic        ramp_en = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int irq_cnt = 0;
    int last_wr_adc = 0;
    int trig_adc = 0;

    red_pitaya_acq_double_buf_if sys();

    red_pitaya_acq_double_buf dut (
        .adc_clk_i (clk),
        .adc_rst_i (srst),
        .adc_dat_i (adc_dat),
        .trig_i    (trig),
        .irq_o     (irq),
        .sys       (sys.slave)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (ramp_en) adc_dat = adc_dat + 14'd1;
        end
    end

    always @(negedge clk) begin
        if (irq) irq_cnt <= irq_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] sx14(input int v);
        logic [13:0] t;
        t = 14'(v);
        return {{18{t[13]}}, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("  ok %s: %h", name, act);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        sys.sys_addr  = a;
        sys.sys_wdata = d;
        sys.sys_wen   = 1'b1;
        @(posedge clk); #1;
        last_wr_adc = int'(adc_dat);
        sys.sys_wen = 1'b0;
        check($sformatf("wr_ack[%h]", a), 32'(sys.sys_ack), 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(posedge clk); #1;
        sys.sys_addr = a;
        sys.sys_ren  = 1'b1;
        @(posedge clk); #1;
        sys.sys_ren = 1'b0;
        lat = 1;
        while (!sys.sys_ack && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("rd_ack[%h]", a), 32'(sys.sys_ack), 32'd1);
        d = sys.sys_rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int lat;
        bus_read(a, d, lat);
        check(name, d, exp);
    endtask

    task automatic ext_trigger();
        @(posedge clk); #1;
        trig = 1'b1;
        @(posedge clk); #1;
        trig_adc = int'(adc_dat);
        @(posedge clk); #1;
        trig = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int lat;
        int r0;
        int irq_before;

        sys.sys_addr  = '0;
        sys.sys_wdata = '0;
        sys.sys_sel   = 4'hF;
        sys.sys_wen   = 1'b0;
        sys.sys_ren   = 1'b0;

        srst = 1'b1;
        wait_cycles(3);
        srst = 1'b0;
        check("irq_after_reset", 32'(irq), 32'd0);

        // Register map table: reset values, clamping, readback of stored CTRL bits.
        vecs.push_back('{1'b0, REG_STATUS,  32'h0,        32'h0000_0010});
        vecs.push_back('{1'b0, REG_CTRL,    32'h0,        32'h0});
        vecs.push_back('{1'b0, REG_DEC,     32'h0,        32'h1});
        vecs.push_back('{1'b0, REG_LEN,     32'h0,        32'h4000});
        vecs.push_back('{1'b0, 32'h14,      32'h0,        32'h0});
        vecs.push_back('{1'b1, 32'h14,      32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, REG_STATUS,  32'h0,        32'h0000_0010});
        vecs.push_back('{1'b1, REG_LEN,     32'h0,        32'h0});
        vecs.push_back('{1'b0, REG_LEN,     32'h0,        32'h4000});
        vecs.push_back('{1'b1, REG_LEN,     32'h4001,     32'h0});
        vecs.push_back('{1'b0, REG_LEN,     32'h0,        32'h4000});
        vecs.push_back('{1'b1, REG_LEN,     32'h8,        32'h0});
        vecs.push_back('{1'b0, REG_LEN,     32'h0,        32'h8});
        vecs.push_back('{1'b1, REG_DEC,     32'h0,        32'h0});
        vecs.push_back('{1'b0, REG_DEC,     32'h0,        32'h0});
        vecs.push_back('{1'b1, REG_DEC,     32'h1,        32'h0});
        vecs.push_back('{1'b0, REG_DEC,     32'h0,        32'h1});
        vecs.push_back('{1'b1, REG_CTRL,    32'h24,       32'h0});
        vecs.push_back('{1'b0, REG_CTRL,    32'h0,        32'h24});
        vecs.push_back('{1'b1, REG_CTRL,    32'h0A,       32'h0});
        vecs.push_back('{1'b0, REG_CTRL,    32'h0,        32'h0});
        vecs.push_back('{1'b0, REG_STATUS,  32'h0,        32'h0000_0010});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                read_check($sformatf("vec%0d[%h]", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
            end
        end
        check("irq_idle", 32'(irq_cnt), 32'd0);

        // Software trigger, DEC=1, LEN=8 into bank 0.
        bus_write(REG_DEC, 32'd1);
        bus_write(REG_LEN, 32'd8);
        bus_write(REG_CTRL, 32'h11);
        bus_write(REG_CTRL, 32'h18);
        r0 = last_wr_adc + 1;
        wait_cycles(20);
        check("sw_irq_count", 32'(irq_cnt), 32'd1);
        read_check("sw_status", REG_STATUS, 32'h0008_0004);
        read_check("sw_ctrl", REG_CTRL, 32'h10);
        bus_read(RAM_BASE, d, lat);
        check("ram_latency", 32'(lat), 32'd2);
        check("sw_ram0", d, sx14(r0));
        for (int k = 1; k < 8; k++) begin
            read_check($sformatf("sw_ram%0d", k), RAM_BASE + 32'(4 * k), sx14(r0 + k));
        end

        // External trigger, DEC=3, LEN=4 into bank 1.
        bus_write(REG_RELEASE, 32'd1);
        read_check("released", REG_STATUS, 32'h0008_0000);
        bus_write(REG_DEC, 32'd3);
        bus_write(REG_LEN, 32'd4);
        bus_write(REG_CTRL, 32'h21);
        ext_trigger();
        r0 = trig_adc + 1;
        wait_cycles(30);
        check("ext_irq_count", 32'(irq_cnt), 32'd2);
        read_check("ext_status", REG_STATUS, 32'h0004_0014);
        for (int k = 0; k < 4; k++) begin
            read_check($sformatf("ext_ram%0d", k), RAM_BASE + 32'(4 * k), sx14(r0 + 3 * k));
        end

        // Continuous mode: second capture without release overruns.
        bus_write(REG_RELEASE, 32'd1);
        bus_write(REG_DEC, 32'd1);
        bus_write(REG_CTRL, 32'h25);
        ext_trigger();
        r0 = trig_adc + 1;
        wait_cycles(10);
        check("cont1_irq", 32'(irq_cnt), 32'd3);
        read_check("cont1_status", REG_STATUS, 32'h0004_0005);
        ext_trigger();
        wait_cycles(10);
        check("cont2_irq", 32'(irq_cnt), 32'd3);
        read_check("cont2_status", REG_STATUS, 32'h0004_000D);
        read_check("cont2_ram0", RAM_BASE, sx14(r0));
        bus_write(REG_RELEASE, 32'd1);
        ext_trigger();
        r0 = trig_adc + 1;
        wait_cycles(10);
        check("cont3_irq", 32'(irq_cnt), 32'd4);
        read_check("cont3_status", REG_STATUS, 32'h0004_001D);
        read_check("cont3_ram0", RAM_BASE, sx14(r0));
        bus_write(REG_CTRL, 32'h02);
        read_check("abort_status", REG_STATUS, 32'h0000_0010);

        // Negative sample sign extension, LEN=1, into bank 0.
        ramp_en = 1'b0;
        adc_dat = 14'h3E0C;
        bus_write(REG_LEN, 32'd1);
        bus_write(REG_CTRL, 32'h11);
        bus_write(REG_CTRL, 32'h18);
        wait_cycles(10);
        check("neg_irq", 32'(irq_cnt), 32'd5);
        read_check("neg_status", REG_STATUS, 32'h0001_0004);
        read_check("neg_ram0", RAM_BASE, 32'hFFFF_FE0C);

        // Release lands in the SWAP cycle: swap proceeds without overrun.
        adc_dat = 14'h0123;
        bus_write(REG_CTRL, 32'h11);
        bus_write(REG_CTRL, 32'h18);
        bus_write(REG_RELEASE, 32'd1);
        wait_cycles(5);
        check("relswap_irq", 32'(irq_cnt), 32'd6);
        read_check("relswap_status", REG_STATUS, 32'h0001_0014);
        read_check("relswap_ram0", RAM_BASE, 32'h0000_0123);
        ramp_en = 1'b1;

        // Abort mid-capture.
        bus_write(REG_CTRL, 32'h02);
        bus_write(REG_LEN, 32'd1000);
        bus_write(REG_CTRL, 32'h11);
        bus_write(REG_CTRL, 32'h18);
        wait_cycles(10);
        read_check("midcap_status", REG_STATUS, 32'h0000_0012);
        irq_before = irq_cnt;
        bus_write(REG_CTRL, 32'h02);
        read_check("abort_cap_status", REG_STATUS, 32'h0000_0010);
        wait_cycles(1100);
        check("abort_no_irq", 32'(irq_cnt), 32'(irq_before));
        read_check("abort_late_status", REG_STATUS, 32'h0000_0010);

        // Reset mid-capture.
        bus_write(REG_CTRL, 32'h11);
        bus_write(REG_CTRL, 32'h18);
        wait_cycles(10);
        pulse_reset();
        read_check("rst_status", REG_STATUS, 32'h0000_0010);
        read_check("rst_len", REG_LEN, 32'h4000);
        wait_cycles(1100);
        check("rst_no_irq", 32'(irq_cnt), 32'(irq_before));
        read_check("rst_late_status", REG_STATUS, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
